// File: rtl/gate_bus_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_bus_serializer_pkg
// Description : Shared baseblocks constants, FSM state encoding and clog2
//               helper for the gate-bus parallel-to-serial stage.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_bus_serializer_pkg;

   // Shift direction selectors
   localparam int c_lsb_first   = 0;
   localparam int c_msb_first   = 1;

   // SCLR versus CE interaction selectors
   localparam int c_override    = 0;
   localparam int c_no_override = 1;

   // Serializer FSM encoding
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Ceiling log2; returns 0 for values of 0 or 1
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage : gate_bus_serializer_pkg
`default_nettype wire

// File: rtl/gate_bus_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_bus_serializer_if
// Description : Parallel-load and serial-out handshake bundle. The master
//               side supplies words and consumes serial bits; the slave side
//               is the serializer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_bus_serializer_if #(
   parameter int C_WIDTH = 16
) ();

   logic [C_WIDTH-1:0] d;
   logic               d_valid;
   logic               d_ready;
   logic               so;
   logic               so_valid;
   logic               so_ready;
   logic               so_last;
   logic               busy;

   modport master (
      output d, d_valid, so_ready,
      input  d_ready, so, so_valid, so_last, busy
   );

   modport slave (
      input  d, d_valid, so_ready,
      output d_ready, so, so_valid, so_last, busy
   );

endinterface : gate_bus_serializer_if
`default_nettype wire

// File: rtl/gate_bus_serializer_shreg.sv
`default_nettype none
// ============================================================================
// Module      : gate_bus_serializer_shreg
// Description : Loadable shift register with zero fill, selectable shift
//               direction and a serial-out tap at the output end.
//               Priority: aclr > clr > load > shift.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_bus_serializer_shreg
   import gate_bus_serializer_pkg::*;
#(
   parameter int C_WIDTH     = 16,
   parameter int C_SHIFT_DIR = 0
) (
   input  logic               clk,
   input  logic               aclr,
   input  logic               clr,
   input  logic               load,
   input  logic               shift,
   input  logic [C_WIDTH-1:0] din,
   output logic               so
);

   logic [C_WIDTH-1:0] r_shreg;
   logic [C_WIDTH-1:0] w_shifted;

   generate
      if (C_SHIFT_DIR == c_lsb_first) begin : g_lsb
         // Bit 0 leaves first; data moves down and zeros enter at the top
         assign w_shifted = r_shreg >> 1;
         assign so        = r_shreg[0];
      end else begin : g_msb
         // Top bit leaves first; data moves up and zeros enter at bit 0
         assign w_shifted = r_shreg << 1;
         assign so        = r_shreg[C_WIDTH-1];
      end
   endgenerate

   // Shift register: clear, parallel load or one-position shift
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_shreg <= '0;
      end else if (clr) begin
         r_shreg <= '0;
      end else if (load) begin
         r_shreg <= din;
      end else if (shift) begin
         r_shreg <= w_shifted;
      end
   end

endmodule : gate_bus_serializer_shreg
`default_nettype wire

// File: rtl/gate_bus_serializer.sv
`default_nettype none
// ============================================================================
// Module      : gate_bus_serializer
// Description : Parallel-to-serial stage for the registered gate-bus output.
//               Accepts one word per handshake and emits it one bit per
//               serial transfer with valid/ready backpressure. A word can be
//               reloaded on the final bit transfer so consecutive words run
//               without an idle cycle. Honours optional CE and SCLR.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_bus_serializer
   import gate_bus_serializer_pkg::*;
#(
   parameter int C_WIDTH       = 16,
   parameter int C_SHIFT_DIR   = 0,
   parameter int C_HAS_CE      = 0,
   parameter int C_HAS_SCLR    = 0,
   parameter int C_SYNC_ENABLE = 0
) (
   input  logic                 clk,
   input  logic                 aclr,
   input  logic                 ce,
   input  logic                 sclr,
   gate_bus_serializer_if.slave bus
);

   // Counter holds bits remaining after the current one; at least one bit wide
   localparam int c_cnt_w = (clog2(C_WIDTH) < 1) ? 1 : clog2(C_WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_max      = c_cnt_w'(C_WIDTH - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
   localparam logic               c_last_on_load = (C_WIDTH == 1);

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_last;

   logic                 w_en;
   logic                 w_sclr_eff;
   logic                 w_valid;
   logic                 w_xfer;
   logic                 w_last_xfer;
   logic                 w_ready;
   logic                 w_load;
   logic                 w_shift;

   // Effective enable and clear; SCLR either overrides CE or waits for it
   assign w_en       = (C_HAS_CE != 0) ? ce : 1'b1;
   assign w_sclr_eff = (C_HAS_SCLR == 0)              ? 1'b0 :
                       (C_SYNC_ENABLE == c_override)  ? sclr :
                                                        (sclr & w_en);

   assign w_valid     = (r_state == ST_SHIFT);
   assign w_xfer      = w_valid & bus.so_ready & w_en;
   assign w_last_xfer = w_xfer & (r_cnt == '0);

   // A new word is accepted when idle or while the final bit is leaving
   assign w_ready = ~aclr & w_en & ~w_sclr_eff & ((r_state == ST_IDLE) | w_last_xfer);
   assign w_load  = bus.d_valid & w_ready;
   assign w_shift = w_xfer & (r_cnt != '0);

   gate_bus_serializer_shreg #(
      .C_WIDTH     (C_WIDTH),
      .C_SHIFT_DIR (C_SHIFT_DIR)
   ) u_shreg (
      .clk   (clk),
      .aclr  (aclr),
      .clr   (w_sclr_eff),
      .load  (w_load),
      .shift (w_shift),
      .din   (bus.d),
      .so    (bus.so)
   );

   // Control FSM: state, remaining-bit counter and registered last flag
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b0;
      end else if (w_sclr_eff) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b0;
      end else if (w_en) begin
         case (r_state)
            ST_IDLE: begin
               if (w_load) begin
                  r_state <= ST_SHIFT;
                  r_cnt   <= c_cnt_max;
                  r_last  <= c_last_on_load;
               end
            end
            ST_SHIFT: begin
               if (w_xfer) begin
                  if (r_cnt != '0) begin
                     r_cnt  <= r_cnt - c_cnt_one;
                     r_last <= (r_cnt == c_cnt_one);
                  end else if (w_load) begin
                     r_cnt  <= c_cnt_max;
                     r_last <= c_last_on_load;
                  end else begin
                     r_state <= ST_IDLE;
                     r_last  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_last  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.d_ready  = w_ready;
   assign bus.so_valid = w_valid;
   assign bus.busy     = w_valid;
   assign bus.so_last  = r_last;

endmodule : gate_bus_serializer
`default_nettype wire

// File: tb/tb_gate_bus_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_bus_serializer
// Description : Scoreboard bench for gate_bus_serializer. Three instances:
//               A = 8-bit LSB-first, CE+SCLR, SCLR overrides CE
//               B = 8-bit MSB-first, CE+SCLR, SCLR waits for CE
//               C = 1-bit, CE and SCLR ports ignored
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_bus_serializer;

   logic clk;
   logic aclr;
   logic a_ce, a_sclr, b_ce, b_sclr, c_ce, c_sclr;

   int checks   = 0;
   int failures = 0;

   logic [1:0] q_a[$];
   logic [1:0] q_b[$];
   logic [1:0] q_c[$];
   logic [1:0] ea, eb, ec;

   gate_bus_serializer_if #(.C_WIDTH(8)) a_bus ();
   gate_bus_serializer_if #(.C_WIDTH(8)) b_bus ();
   gate_bus_serializer_if #(.C_WIDTH(1)) c_bus ();

   gate_bus_serializer #(
      .C_WIDTH(8), .C_SHIFT_DIR(0), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_SYNC_ENABLE(0)
   ) u_a (.clk(clk), .aclr(aclr), .ce(a_ce), .sclr(a_sclr), .bus(a_bus));

   gate_bus_serializer #(
      .C_WIDTH(8), .C_SHIFT_DIR(1), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_SYNC_ENABLE(1)
   ) u_b (.clk(clk), .aclr(aclr), .ce(b_ce), .sclr(b_sclr), .bus(b_bus));

   gate_bus_serializer #(
      .C_WIDTH(1), .C_SHIFT_DIR(0), .C_HAS_CE(0), .C_HAS_SCLR(0), .C_SYNC_ENABLE(0)
   ) u_c (.clk(clk), .aclr(aclr), .ce(c_ce), .sclr(c_sclr), .bus(c_bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cmp_bit(input string name, input logic so, input logic last, input logic [1:0] e);
      checks++;
      if ({so, last} !== e) begin
         failures++;
         $display("FAIL %s so/last actual=%0b/%0b required=%0b/%0b", name, so, last, e[1], e[0]);
      end
   endtask

   task automatic unexpected(input string name, input logic so);
      checks++;
      failures++;
      $display("FAIL %s actual=bit %0b required=no transfer", name, so);
   endtask

   // bits are listed in transmission order, first bit at bits[n-1]
   task automatic push_word(input int inst, input logic [7:0] bits, input int n);
      logic [1:0] e;
      for (int i = n - 1; i >= 0; i--) begin
         e = {bits[i], (i == 0)};
         case (inst)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors: pop expected bit on every serial transfer
   always @(negedge clk) begin
      if (!aclr && a_bus.so_valid && a_bus.so_ready && a_ce) begin
         if (q_a.size() == 0) unexpected("a_unexpected", a_bus.so);
         else begin ea = q_a.pop_front(); cmp_bit("a_bit", a_bus.so, a_bus.so_last, ea); end
      end
   end

   always @(negedge clk) begin
      if (!aclr && b_bus.so_valid && b_bus.so_ready && b_ce) begin
         if (q_b.size() == 0) unexpected("b_unexpected", b_bus.so);
         else begin eb = q_b.pop_front(); cmp_bit("b_bit", b_bus.so, b_bus.so_last, eb); end
      end
   end

   always @(negedge clk) begin
      if (!aclr && c_bus.so_valid && c_bus.so_ready) begin
         if (q_c.size() == 0) unexpected("c_unexpected", c_bus.so);
         else begin ec = q_c.pop_front(); cmp_bit("c_bit", c_bus.so, c_bus.so_last, ec); end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic prev_so, prev_last, prev_rdy;

      aclr = 1'b1;
      a_ce = 1'b1; a_sclr = 1'b0;
      b_ce = 1'b1; b_sclr = 1'b0;
      c_ce = 1'b1; c_sclr = 1'b0;
      a_bus.d = '0; a_bus.d_valid = 1'b0; a_bus.so_ready = 1'b0;
      b_bus.d = '0; b_bus.d_valid = 1'b0; b_bus.so_ready = 1'b0;
      c_bus.d = '0; c_bus.d_valid = 1'b0; c_bus.so_ready = 1'b0;

      // Reset state
      tick(); tick();
      check("reset_outputs_a", {a_bus.so, a_bus.so_valid, a_bus.so_last, a_bus.busy, a_bus.d_ready}, 0);
      check("reset_outputs_b", {b_bus.so, b_bus.so_valid, b_bus.so_last, b_bus.busy, b_bus.d_ready}, 0);
      aclr = 1'b0;
      #1;
      check("idle_ready_a", a_bus.d_ready, 1);
      check("idle_valid_a", a_bus.so_valid, 0);

      // LSB-first single word 8'hA5
      a_bus.d = 8'hA5; a_bus.d_valid = 1'b1; a_bus.so_ready = 1'b1;
      push_word(0, 8'b10100101, 8);
      tick();
      a_bus.d_valid = 1'b0;
      check("a_first_latency", a_bus.so_valid, 1);
      n = 0;
      while (a_bus.busy && n < 20) begin
         tick();
         n++;
      end
      check("a_word_cycles", n, 8);
      check("a_idle_after", {a_bus.busy, a_bus.so_valid, a_bus.so_last}, 0);

      // Backpressure: ready alternates 0,1,... over the valid cycles of 8'h3C
      a_bus.d = 8'h3C; a_bus.d_valid = 1'b1; a_bus.so_ready = 1'b1;
      push_word(0, 8'b00111100, 8);
      tick();
      a_bus.d_valid = 1'b0;
      n = 0;
      while (a_bus.busy && n < 40) begin
         a_bus.so_ready = ~a_bus.so_ready;
         prev_so   = a_bus.so;
         prev_last = a_bus.so_last;
         prev_rdy  = a_bus.so_ready;
         tick();
         n++;
         if (!prev_rdy && a_bus.busy)
            check("a_bp_hold", {a_bus.so, a_bus.so_last}, {prev_so, prev_last});
      end
      check("a_bp_cycles", n, 16);

      // ACLR mid-word
      a_bus.d = 8'hA5; a_bus.d_valid = 1'b1; a_bus.so_ready = 1'b0;
      tick();
      a_bus.d_valid = 1'b0;
      tick();
      check("a_busy_before_aclr", a_bus.busy, 1);
      aclr = 1'b1;
      a_bus.d_valid = 1'b1;
      #1;
      check("a_aclr_immediate", {a_bus.so, a_bus.so_valid, a_bus.so_last, a_bus.busy, a_bus.d_ready}, 0);
      a_bus.d_valid = 1'b0;
      tick();
      aclr = 1'b0;
      #1;
      check("a_ready_after_aclr", a_bus.d_ready, 1);
      tick(); tick();
      check("a_no_stray_valid", a_bus.so_valid, 0);

      // SCLR overrides CE=0
      a_bus.d = 8'hA5; a_bus.d_valid = 1'b1; a_bus.so_ready = 1'b0;
      tick();
      a_bus.d_valid = 1'b0;
      check("a_sclr_pre", {a_bus.busy, a_bus.so}, 2'b11);
      a_ce = 1'b0; a_sclr = 1'b1;
      #1;
      check("a_ready_ce0", a_bus.d_ready, 0);
      tick();
      check("a_sclr_override", {a_bus.busy, a_bus.so_valid, a_bus.so}, 0);
      a_sclr = 1'b0; a_ce = 1'b1;
      #1;
      check("a_ready_after_sclr", a_bus.d_ready, 1);

      // MSB-first back-to-back 8'hF0 then 8'h0F
      b_bus.d = 8'hF0; b_bus.d_valid = 1'b1; b_bus.so_ready = 1'b1;
      push_word(1, 8'b11110000, 8);
      push_word(1, 8'b00001111, 8);
      tick();
      b_bus.d = 8'h0F;
      for (int i = 1; i <= 16; i++) begin
         check("b_contiguous_valid", b_bus.so_valid, 1);
         if (i <= 15) check("b_ready_slot", b_bus.d_ready, (i == 8));
         tick();
         if (i == 8) b_bus.d_valid = 1'b0;
      end
      check("b_idle_after", b_bus.busy, 0);

      // CE=0 freezes B; SCLR waits for CE when not overriding
      b_bus.d = 8'hA5; b_bus.d_valid = 1'b1; b_bus.so_ready = 1'b0;
      tick();
      b_bus.d_valid = 1'b0;
      check("b_first_msb", {b_bus.busy, b_bus.so}, 2'b11);
      b_ce = 1'b0; b_bus.so_ready = 1'b1;
      tick(); tick();
      check("b_ce_hold", {b_bus.busy, b_bus.so, b_bus.so_last}, 3'b110);
      b_bus.so_ready = 1'b0; b_sclr = 1'b1;
      #1;
      check("b_ready_sclr_ce0", b_bus.d_ready, 0);
      tick();
      check("b_sclr_held", b_bus.busy, 1);
      b_ce = 1'b1;
      #1;
      check("b_ready_sclr_ce1", b_bus.d_ready, 0);
      tick();
      check("b_sclr_applied", {b_bus.busy, b_bus.so}, 0);
      b_sclr = 1'b0;
      #1;
      check("b_ready_after_sclr", b_bus.d_ready, 1);

      // Width 1, full rate, CE/SCLR ports ignored
      c_ce = 1'b0; c_sclr = 1'b1;
      c_bus.d = 1'b1; c_bus.d_valid = 1'b1; c_bus.so_ready = 1'b1;
      #1;
      check("c_ready0", c_bus.d_ready, 1);
      push_word(2, 8'b1, 1);
      tick();
      c_bus.d = 1'b0;
      push_word(2, 8'b0, 1);
      check("c_ready1", {c_bus.d_ready, c_bus.so_last}, 2'b11);
      tick();
      c_bus.d = 1'b1;
      push_word(2, 8'b1, 1);
      check("c_ready2", {c_bus.d_ready, c_bus.so_last}, 2'b11);
      tick();
      c_bus.d_valid = 1'b0;
      check("c_ready3", {c_bus.d_ready, c_bus.so_last}, 2'b11);
      tick();
      check("c_idle_after", c_bus.busy, 0);

      tick();
      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      check("c_queue_drained", q_c.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_gate_bus_serializer
`default_nettype wire

// File: doc/gate_bus_serializer.md
Name: gate_bus_serializer

Overview:
- Parallel-to-serial stage placed directly downstream of the registered gate-bus output (Q) in the baseblocks library.
- Accepts one C_WIDTH-bit word per handshake and shifts it out one bit per transfer, with valid/ready backpressure on the serial side.
- Supports back-to-back words with no idle bubble.
- Supports the library's CE and synchronous-clear conventions.

Parameters:
- C_WIDTH, 16: word width in bits; legal range 1..64.
- C_SHIFT_DIR, 0: 0 = LSB first; 1 = MSB first.
- C_HAS_CE, 0: 0 = CE port ignored and treated as 1; 1 = CE gates all state updates.
- C_HAS_SCLR, 0: 0 = SCLR port ignored; 1 = SCLR active.
- C_SYNC_ENABLE, 0: 0 (override) = SCLR acts regardless of CE; 1 (no_override) = SCLR acts only when CE=1.

Ports:
- CLK, input, 1: clock; all state updates on rising edge.
- ACLR, input, 1: asynchronous reset, active-high.
- CE, input, 1: clock enable.
- SCLR, input, 1: synchronous clear, active-high.
- D, input, C_WIDTH: parallel word, typically the gate-bus Q.
- D_VALID, input, 1: D holds a word to load.
- D_READY, output, 1: serializer can accept D this cycle (combinational).
- SO, output, 1: current serial bit.
- SO_VALID, output, 1: SO is valid.
- SO_READY, input, 1: consumer takes SO this cycle.
- SO_LAST, output, 1: SO is the final bit of the current word.
- BUSY, output, 1: a word is in flight (state SHIFT).

Behaviour:
- Interface (decided): one clock, CLK. ACLR is an asynchronous, active-high reset.
- ACLR asserted, immediately and independent of CLK:
  - state = IDLE; shift reg = 0; bit counter = 0.
  - SO = 0, SO_VALID = 0, SO_LAST = 0, BUSY = 0, D_READY = 0 while ACLR = 1.
- ACLR deasserted mid-word: the word is lost; the block restarts in IDLE.
- Effective enable: en = CE if C_HAS_CE = 1, else 1. When en = 0 all registers hold, D_READY = 0, and SO/SO_VALID/SO_LAST stay stable.
- SCLR (when C_HAS_SCLR = 1), at a rising edge, subject to C_SYNC_ENABLE:
  - Same effect as ACLR on registered state.
  - Has priority over load and shift in the same cycle.
- Definitions:
  - xfer = SO_VALID & SO_READY & en.
  - last_xfer = xfer & (cnt == 0).
  - D_READY = en & !SCLR_eff & (state == IDLE | last_xfer).
  - load = D_VALID & D_READY.
- State machine:
  - IDLE: on load -> SHIFT; shreg <= D; cnt <= C_WIDTH-1.
  - SHIFT, xfer & cnt != 0: shreg shifts toward the output end and zero-fills; cnt <= cnt-1.
  - SHIFT, last_xfer & load: reload shreg <= D; cnt <= C_WIDTH-1; stay in SHIFT (zero-bubble back-to-back).
  - SHIFT, last_xfer & !load: -> IDLE.
  - SHIFT, !xfer: hold (backpressure).
- Outputs:
  - SO = shreg[0] if C_SHIFT_DIR = 0, else shreg[C_WIDTH-1].
  - SO_VALID = (state == SHIFT). BUSY = SO_VALID.
  - SO_LAST = SO_VALID & (cnt == 0).
- Latency: first bit is valid on the cycle after load. A word with SO_READY held at 1 occupies exactly C_WIDTH cycles.
- C_WIDTH = 1: cnt is always 0, SO_LAST is asserted on every valid bit, and one word is accepted per cycle at full rate.
- Counter width: clog2(C_WIDTH), minimum 1 bit. cnt never wraps below 0.
- D_VALID asserted while D_READY = 0: no effect. D is sampled only on load.
- X on D propagates to SO unchanged. No X on any control output after reset.

Decomposition:
- Shared package (baseblocks constants):
  - c_lsb_first = 0, c_msb_first = 1.
  - c_override = 0, c_no_override = 1.
  - State encoding: IDLE = 0, SHIFT = 1.
  - clog2 function.
- One sub-module: gate_bus_serializer_shreg, a loadable shift register with direction parameter, load/shift/clear controls and serial-out tap.
- FSM and counter stay in the top level.

Test Plan:
- Reset/idle: ACLR pulse mid-stream -> all outputs 0 immediately; after release D_READY = 1 with CE = 1 and no stray SO_VALID.
- LSB-first single word: C_WIDTH = 8, D = 8'hA5 loaded, SO_READY = 1 -> SO sequence 1,0,1,0,0,1,0,1 over 8 cycles; SO_LAST only on the 8th; then IDLE.
- MSB-first back-to-back: C_SHIFT_DIR = 1, words 8'hF0 then 8'h0F with D_VALID held -> 16 contiguous valid bits 11110000 00001111; D_READY high on cycle 8 only; no bubble.
- Backpressure: SO_READY toggles 1,0,1,0 during word 8'h3C -> each bit held stable while SO_READY = 0; completion after 16 cycles; bit order intact.
- CE/SCLR priority: C_HAS_CE = 1, C_HAS_SCLR = 1, C_SYNC_ENABLE = 0; CE = 0 with SCLR = 1 mid-word -> cleared to IDLE next edge. Repeat with C_SYNC_ENABLE = 1 -> state holds until CE = 1.
- C_WIDTH = 1: D_VALID held with alternating D = 1,0,1 -> SO = 1,0,1 on consecutive cycles; SO_LAST = 1 each cycle; D_READY continuously 1.
